// File: rtl/fact_seq_ctrl.sv
// Iterative factorial sequencer: accepts n, runs one multiply round per clock,
// and returns n! mod 2^W with sticky overflow through a valid/ready handshake.
module fact_seq_ctrl #(
  parameter int W          = 8,
  parameter int MAX_N      = 8,
  parameter int CONST_TIME = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         ovf,
  output logic         err,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic         CT_MODE = (CONST_TIME != 0);
  localparam logic [W-1:0] ZERO    = {W{1'b0}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_N_W = W'(MAX_N);

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_i, r_fact, r_n_q, r_cnt, r_res;
  logic           r_ovf, r_err;
  logic [W-1:0]   w_i_nxt, w_fact_nxt, w_n_q_nxt, w_cnt_nxt, w_res_nxt;
  logic           w_ovf_nxt, w_err_nxt;
  logic [2*W-1:0] w_prod;
  logic           w_last_round;

  assign w_prod = {{W{1'b0}}, r_fact} * {{W{1'b0}}, r_i};

  // Round count decides termination in constant-time mode, i==n_q otherwise.
  assign w_last_round = CT_MODE ? (r_cnt == (MAX_N_W - ONE)) : (r_i == r_n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_i     <= ZERO;
      r_fact  <= ZERO;
      r_n_q   <= ZERO;
      r_cnt   <= ZERO;
      r_res   <= ZERO;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_fact  <= w_fact_nxt;
      r_n_q   <= w_n_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
      r_ovf   <= w_ovf_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_fact_nxt  = r_fact;
    w_n_q_nxt   = r_n_q;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    w_ovf_nxt   = r_ovf;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_n_q_nxt   = n;
          w_i_nxt     = ONE;
          w_fact_nxt  = ONE;
          w_res_nxt   = (n == ZERO) ? ONE : ZERO;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = ZERO;
          w_err_nxt   = CT_MODE & (n > MAX_N_W);
          w_state_nxt = (!CT_MODE && (n == ZERO)) ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        // Padding rounds (i > n_q) keep fact moving but never touch res or ovf.
        w_fact_nxt = w_prod[W-1:0];
        w_res_nxt  = r_res + ((r_i == r_n_q) ? w_prod[W-1:0] : ZERO);
        w_i_nxt    = r_i + ONE;
        w_cnt_nxt  = r_cnt + ONE;
        w_ovf_nxt  = r_ovf | ((r_i <= r_n_q) && (w_prod[2*W-1:W] != ZERO));
        if (w_last_round) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign res       = r_res;
  assign ovf       = r_ovf;
  assign err       = r_err;

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// Directed bench for fact_seq_ctrl: instance 0 runs variable-latency mode,
// instance 1 runs constant-time mode with MAX_N=8.
module tb_fact_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] in_valid, in_ready, out_valid, out_ready, ovf, err, busy;
  logic [7:0] n_s   [2];
  logic [7:0] res_s [2];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int m;
    int nv;
    int res;
    int ovf;
    int err;
    int lat;
    int busy;
  } vec_t;

  vec_t tbl[11];

  fact_seq_ctrl #(.W(8), .MAX_N(8), .CONST_TIME(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .n(n_s[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .res(res_s[0]), .ovf(ovf[0]), .err(err[0]), .busy(busy[0])
  );

  fact_seq_ctrl #(.W(8), .MAX_N(8), .CONST_TIME(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .n(n_s[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .res(res_s[1]), .ovf(ovf[1]), .err(err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input int m, input string tag);
    chk({tag, " res"},       int'(res_s[m]),     0);
    chk({tag, " ovf"},       int'(ovf[m]),       0);
    chk({tag, " err"},       int'(err[m]),       0);
    chk({tag, " out_valid"}, int'(out_valid[m]), 0);
    chk({tag, " busy"},      int'(busy[m]),      0);
    chk({tag, " in_ready"},  int'(in_ready[m]),  1);
  endtask

  // Accept a request and count edges until out_valid, plus busy / in_ready-low cycles.
  task automatic run_vec(input vec_t v);
    int    edges, busy_c, nrdy_c;
    string tag;
    tag = $sformatf("m%0d n=%0d", v.m, v.nv);
    @(negedge clk);
    in_valid[v.m] = 1'b1;
    n_s[v.m]      = 8'(v.nv);
    @(posedge clk); #1;
    in_valid[v.m] = 1'b0;
    edges  = 1;
    busy_c = 0;
    nrdy_c = 0;
    while (!out_valid[v.m] && edges < 300) begin
      if (busy[v.m])      busy_c++;
      if (!in_ready[v.m]) nrdy_c++;
      @(posedge clk); #1;
      edges++;
    end
    if (!in_ready[v.m]) nrdy_c++;
    chk({tag, " latency"}, edges, v.lat);
    chk({tag, " res"},     int'(res_s[v.m]), v.res);
    chk({tag, " ovf"},     int'(ovf[v.m]),   v.ovf);
    chk({tag, " err"},     int'(err[v.m]),   v.err);
    chk({tag, " busy cycles"}, busy_c, v.busy);
    chk({tag, " in_ready low cycles"}, nrdy_c, v.lat);
    @(posedge clk); #1;
    chk({tag, " back to idle"}, int'(in_ready[v.m]), 1);
    chk({tag, " out_valid drop"}, int'(out_valid[v.m]), 0);
  endtask

  task automatic reset_mid_run(input int m, input int nv);
    string tag;
    tag = $sformatf("rst mid-run m%0d", m);
    @(negedge clk);
    in_valid[m] = 1'b1;
    n_s[m]      = 8'(nv);
    @(posedge clk); #1;
    in_valid[m] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " busy before"}, int'(busy[m]), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle(m, tag);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid[m]) chk({tag, " spurious out_valid"}, 1, 0);
    end
  endtask

  initial begin
    vec_t h;
    int   edges;

    tbl[0]  = '{m: 0, nv: 5, res: 8'h78, ovf: 0, err: 0, lat: 6, busy: 5};
    tbl[1]  = '{m: 0, nv: 0, res: 8'h01, ovf: 0, err: 0, lat: 1, busy: 0};
    tbl[2]  = '{m: 0, nv: 1, res: 8'h01, ovf: 0, err: 0, lat: 2, busy: 1};
    tbl[3]  = '{m: 0, nv: 6, res: 8'hD0, ovf: 1, err: 0, lat: 7, busy: 6};
    tbl[4]  = '{m: 0, nv: 4, res: 8'h18, ovf: 0, err: 0, lat: 5, busy: 4};
    tbl[5]  = '{m: 0, nv: 2, res: 8'h02, ovf: 0, err: 0, lat: 3, busy: 2};
    tbl[6]  = '{m: 1, nv: 3, res: 8'h06, ovf: 0, err: 0, lat: 9, busy: 8};
    tbl[7]  = '{m: 1, nv: 7, res: 8'hB0, ovf: 1, err: 0, lat: 9, busy: 8};
    tbl[8]  = '{m: 1, nv: 9, res: 8'h00, ovf: 1, err: 1, lat: 9, busy: 8};
    tbl[9]  = '{m: 1, nv: 0, res: 8'h01, ovf: 0, err: 0, lat: 9, busy: 8};
    tbl[10] = '{m: 1, nv: 8, res: 8'h80, ovf: 1, err: 0, lat: 9, busy: 8};

    rst       = 1'b1;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    n_s[0]    = 8'd0;
    n_s[1]    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle(0, "reset m0");
    chk_idle(1, "reset m1");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      run_vec(tbl[k]);
    end

    // Result held while the consumer stalls; a competing request must wait.
    @(negedge clk);
    in_valid[0]  = 1'b1;
    n_s[0]       = 8'd4;
    out_ready[0] = 1'b0;
    @(posedge clk); #1;
    n_s[0] = 8'd7;
    edges  = 1;
    while (!out_valid[0] && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("stall latency", edges, 5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall out_valid", int'(out_valid[0]), 1);
      chk("stall res",       int'(res_s[0]),     8'h18);
      chk("stall in_ready",  int'(in_ready[0]),  0);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b0;
    @(posedge clk); #1;
    chk("release in_ready",  int'(in_ready[0]),  1);
    chk("release out_valid", int'(out_valid[0]), 0);
    chk("release busy",      int'(busy[0]),      0);

    reset_mid_run(0, 5);
    h = '{m: 0, nv: 3, res: 8'h06, ovf: 0, err: 0, lat: 4, busy: 3};
    run_vec(h);

    reset_mid_run(1, 9);
    h = '{m: 1, nv: 3, res: 8'h06, ovf: 0, err: 0, lat: 9, busy: 8};
    run_vec(h);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fact_seq_ctrl.md
Name: fact_seq_ctrl

Overview:
- Sequencer for the iterative factorial round datapath (state res/i/fact, one round per step).
- Accepts a request carrying n, then iterates rounds i = 1..n with one round per clock.
- Returns n! mod 2^W through a valid/ready result handshake.
- Optional constant-time mode always runs MAX_N rounds regardless of n, so latency does not leak n (needed for the encrypted-execution benchmarks).

Parameters:
- W, 8: datapath width; all arithmetic is mod 2^W.
- MAX_N, 8: round count in constant-time mode; legal range 1..2^W-1.
- CONST_TIME, 0: 0 = run n rounds; 1 = always run MAX_N rounds.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- n  in  W  operand, sampled on accept.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- res  out  W  n! mod 2^W.
- ovf  out  1  sticky; a round with i<=n produced a product of 2^W or more.
- err  out  1  CONST_TIME=1 and n>MAX_N.
- busy  out  1  high in RUN.

Behaviour:
- Reset: the one clock is clk; reset is rst, synchronous and active-high.
  - rst=1 at any edge forces state=IDLE and zeroes res, i, fact, n_q, cnt, ovf and err.
  - Reset applies mid-RUN or mid-DONE as well; an in-flight request is dropped and no result is issued.
  - rst has priority over every other event.
- State IDLE: in_ready=1. On accept (in_valid & in_ready) the block loads:
  - n_q=n, i=1, fact=1, res=(n==0)?1:0, ovf=0, cnt=0.
  - err = CONST_TIME & (n>MAX_N).
  - Next state is DONE if CONST_TIME=0 and n==0; otherwise RUN.
- State RUN: each edge applies one round on full-width products:
  - p = fact*i, computed 2W bits wide.
  - fact <= p[W-1:0].
  - res <= res + ((i==n_q) ? p[W-1:0] : 0), mod 2^W.
  - i <= i+1, mod 2^W.
  - cnt <= cnt+1.
  - ovf <= ovf | ((i<=n_q) & (p[2W-1:W]!=0)).
- Leaving RUN:
  - CONST_TIME=0: go to DONE on the edge that executes the round with i==n_q.
  - CONST_TIME=1: go to DONE on the edge where cnt==MAX_N-1, i.e. after exactly MAX_N rounds.
  - Rounds with i>n_q still update fact but never touch res or ovf.
- State DONE: out_valid=1; res, ovf and err are held stable.
  - On out_valid & out_ready, return to IDLE.
  - in_ready=0 here, so a new request cannot overlap the result handshake.
- Latency, from accept edge to the first cycle with out_valid=1:
  - CONST_TIME=0: n+1 edges (1 edge when n==0).
  - CONST_TIME=1: MAX_N+1 edges.
  - Throughput is one request per latency+1 cycles at best, because IDLE costs one cycle.
- Outputs are registered.
  - res is the res register.
  - busy = (state==RUN).
  - ovf and err show the register values in every state; consumers treat them as meaningful only with out_valid.
- Boundary cases:
  - n=1 gives res=1.
  - err=1 implies res=0, because i never equals n_q within MAX_N rounds.
  - i never wraps in either mode: max n is 2^W-1, and MAX_N <= 2^W-1.
  - in_valid asserted while not IDLE is ignored and must be held by the source.
  - Illegal state encodings recover to IDLE.

Test Plan:
- CONST_TIME=0, n=5, out_ready=1:
  - in_ready low for 6 cycles after accept.
  - busy high for 5 cycles.
  - out_valid on the 6th edge with res=0x78, ovf=0, err=0.
- CONST_TIME=0, n=0: out_valid 1 edge after accept, res=0x01, busy never asserts. Also n=1 -> res=0x01 after 2 edges.
- CONST_TIME=0, n=6: res=0xD0 (720 mod 256), ovf=1.
- CONST_TIME=0, back-to-back requests n=6 then n=4: ovf is cleared on the second accept, giving res=0x18, ovf=0.
- CONST_TIME=1, MAX_N=8:
  - n=3 and n=7 both give out_valid exactly 9 edges after accept.
  - n=3 -> res=0x06, ovf=0.
  - n=7 -> res=0xB0, ovf=1.
  - n=9 -> res=0x00, err=1, still 9 edges.
- n=4 with out_ready held low for 3 cycles in DONE:
  - res=0x18 stays stable and out_valid stays high.
  - A concurrent in_valid is not accepted.
  - Release out_ready -> IDLE next edge.
- rst pulsed for 1 cycle during RUN of n=5: IDLE with all outputs 0 on the next edge, no out_valid; a following n=3 request gives res=0x06.
